// File: rtl/proc_mem_responder_if.sv
// Bus bundle between the pipeline core, the program loader and the memory responder.
// The responder takes the slave modport; the core/loader side takes master.
interface proc_mem_responder_if;
    logic [15:0] instrAddr;
    logic [31:0] instrMem;
    logic [15:0] memAddr;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] memData;
    logic        ldStart;
    logic        ldSel;
    logic        ldValid;
    logic [31:0] ldData;
    logic        ldLast;
    logic        ldReady;
    logic        ldDone;
    logic        cpuHold;
    logic        errFlag;

    modport slave (
        input  instrAddr, memAddr, writeData, memWrite, memRead,
        input  ldStart, ldSel, ldValid, ldData, ldLast,
        output instrMem, memData, ldReady, ldDone, cpuHold, errFlag
    );

    modport master (
        output instrAddr, memAddr, writeData, memWrite, memRead,
        output ldStart, ldSel, ldValid, ldData, ldLast,
        input  instrMem, memData, ldReady, ldDone, cpuHold, errFlag
    );
endinterface

// File: rtl/proc_mem_responder.sv
// Memory responder for the 5-stage core: instruction and data word arrays,
// a handshaked burst loader, and the CPU hold that keeps the core parked until loading is done.
module proc_mem_responder #(
    parameter int IAW = 8,
    parameter int DAW = 8
) (
    input logic                  i_clock,
    input logic                  i_reset,
    proc_mem_responder_if.slave  bus
);

    localparam int CW = ((IAW > DAW) ? IAW : DAW) + 1;
    localparam logic [CW-1:0] IDEPTH = CW'(2 ** IAW);
    localparam logic [CW-1:0] DDEPTH = CW'(2 ** DAW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_cnt;
    logic          r_sel;
    logic          r_ldDone;
    logic          r_errFlag;

    logic [31:0]   r_iarray [2**IAW];
    logic [31:0]   r_darray [2**DAW];

    logic          w_run;
    logic          w_accept;
    logic          w_start;
    logic [CW-1:0] w_selDepth;
    logic          w_ldFits;
    logic [IAW-1:0] w_instrIdx;
    logic [DAW-1:0] w_memIdx;
    logic          w_instrOor;
    logic          w_memOor;
    logic          w_coreWrite;
    logic          w_errNext;
    logic          w_cpuHold;
    logic          w_ldReady;

    assign w_run      = (r_state == RUN);
    assign w_accept   = (r_state == LOAD) && bus.ldValid;
    // LdStart is only honoured outside LOAD; a burst in flight cannot be restarted.
    assign w_start    = bus.ldStart && (r_state != LOAD);
    assign w_selDepth = r_sel ? DDEPTH : IDEPTH;
    assign w_ldFits   = (r_cnt < w_selDepth);

    assign w_instrIdx = bus.instrAddr[IAW+1:2];
    assign w_memIdx   = bus.memAddr[DAW+1:2];
    assign w_instrOor = |(bus.instrAddr >> (IAW + 2));
    assign w_memOor   = |(bus.memAddr >> (DAW + 2));

    assign w_coreWrite = w_run && bus.memWrite && !w_memOor;
    assign w_errNext   = (w_run && (w_instrOor || ((bus.memRead || bus.memWrite) && w_memOor)))
                       || (w_accept && !w_ldFits);

    always_comb begin
        w_nextState = r_state;
        w_cpuHold   = 1'b1;
        w_ldReady   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ldStart) w_nextState = LOAD;
            end
            LOAD: begin
                w_ldReady = 1'b1;
                if (w_accept && bus.ldLast) w_nextState = RUN;
            end
            RUN: begin
                w_cpuHold = 1'b0;
                if (bus.ldStart) w_nextState = LOAD;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Overflowing loader words leave the counter parked at the array depth.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
            r_ldDone  <= 1'b0;
            r_errFlag <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ldDone  <= w_accept && bus.ldLast;
            r_errFlag <= r_errFlag || w_errNext;
            if (w_start) begin
                r_cnt <= '0;
                r_sel <= bus.ldSel;
            end else if (w_accept && w_ldFits) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && w_accept && w_ldFits && !r_sel) begin
            r_iarray[r_cnt[IAW-1:0]] <= bus.ldData;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (w_accept && w_ldFits && r_sel) begin
                r_darray[r_cnt[DAW-1:0]] <= bus.ldData;
            end else if (w_coreWrite) begin
                r_darray[w_memIdx] <= bus.writeData;
            end
        end
    end

    assign bus.instrMem = (w_run && !w_instrOor) ? r_iarray[w_instrIdx] : 32'h0;
    assign bus.memData  = (w_run && bus.memRead && !w_memOor) ? r_darray[w_memIdx] : 32'h0;
    assign bus.ldReady  = w_ldReady;
    assign bus.cpuHold  = w_cpuHold;
    assign bus.ldDone   = r_ldDone;
    assign bus.errFlag  = r_errFlag;

endmodule
